// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - control-unit state encoding and one-hot trap phase codes
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    TS_IDLE,
    TS_EXC_S1,
    TS_EXC_S2,
    TS_EXC_M1,
    TS_EXC_M2,
    TS_INT_1,
    TS_INT_2,
    TS_INT_3
  } trap_state_e;

  localparam logic [3:0] EXC_CODE_NONE = 4'b0000;
  localparam logic [3:0] EXC_CODE_S1   = 4'b0001;
  localparam logic [3:0] EXC_CODE_S2   = 4'b0100;
  localparam logic [3:0] EXC_CODE_M1   = 4'b0010;
  localparam logic [3:0] EXC_CODE_M2   = 4'b1000;

  localparam logic [2:0] INT_CODE_NONE = 3'b000;
  localparam logic [2:0] INT_CODE_1    = 3'b001;
  localparam logic [2:0] INT_CODE_2    = 3'b010;
  localparam logic [2:0] INT_CODE_3    = 3'b100;

  function automatic logic [3:0] exc_code(trap_state_e s);
    case (s)
      TS_EXC_S1: exc_code = EXC_CODE_S1;
      TS_EXC_S2: exc_code = EXC_CODE_S2;
      TS_EXC_M1: exc_code = EXC_CODE_M1;
      TS_EXC_M2: exc_code = EXC_CODE_M2;
      default:   exc_code = EXC_CODE_NONE;
    endcase
  endfunction

  function automatic logic [2:0] int_code(trap_state_e s);
    case (s)
      TS_INT_1: int_code = INT_CODE_1;
      TS_INT_2: int_code = INT_CODE_2;
      TS_INT_3: int_code = INT_CODE_3;
      default:  int_code = INT_CODE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/trap_pending.sv
// rtl/trap_pending.sv - sticky pending bits for traps and fixed-priority request select
module trap_pending (
  input  logic clk,
  input  logic reset,
  input  logic exc_stack_i,
  input  logic exc_mem_i,
  input  logic int_edge_i,
  input  logic clr_exc_i,
  input  logic clr_int_i,
  output logic fault_pending_o,
  output logic req_stk_o,
  output logic req_mem_o,
  output logic req_int_o
);

  logic pend_stk;
  logic pend_mem;
  logic pend_int;
  logic any_stk;
  logic any_mem;
  logic any_int;

  // Same-cycle sources are folded in so a fault is serviced on the very next edge.
  assign any_stk = pend_stk | exc_stack_i;
  assign any_mem = pend_mem | exc_mem_i;
  assign any_int = pend_int | int_edge_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_stk <= 1'b0;
      pend_mem <= 1'b0;
      pend_int <= 1'b0;
    end else begin
      pend_stk <= any_stk & ~clr_exc_i;
      pend_mem <= any_mem & ~clr_exc_i;
      pend_int <= any_int & ~clr_int_i;
    end
  end

  assign req_stk_o       = any_stk;
  assign req_mem_o       = any_mem & ~any_stk;
  assign req_int_o       = any_int & ~any_stk & ~any_mem;
  assign fault_pending_o = pend_stk | pend_mem;

endmodule

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - exception/interrupt phase sequencer; EPC capture when TRAP_EPC_EN is defined
module trap_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            exc_stack_i,
  input  logic            exc_mem_i,
  input  logic            int_i,
  input  logic [PC_W-1:0] pc_i,
  output logic [3:0]      exceptions_o,
  output logic [2:0]      interrupts_o,
  output logic            busy_o,
  output logic [PC_W-1:0] epc_o
);

  trap_state_e state_q;
  trap_state_e state_n;
  logic        int_q;
  logic        int_edge;
  logic        clr_exc;
  logic        clr_int;
  logic        fault_pending;
  logic        req_stk;
  logic        req_mem;
  logic        req_int;

  always_ff @(posedge clk) begin
    if (reset) int_q <= 1'b0;
    else       int_q <= int_i;
  end

  assign int_edge = int_i & ~int_q;

  trap_pending u_pending (
    .clk             (clk),
    .reset           (reset),
    .exc_stack_i     (exc_stack_i),
    .exc_mem_i       (exc_mem_i),
    .int_edge_i      (int_edge),
    .clr_exc_i       (clr_exc),
    .clr_int_i       (clr_int),
    .fault_pending_o (fault_pending),
    .req_stk_o       (req_stk),
    .req_mem_o       (req_mem),
    .req_int_o       (req_int)
  );

  always_comb begin
    state_n = state_q;
    clr_exc = 1'b0;
    clr_int = 1'b0;
    if (!stall_i) begin
      case (state_q)
        TS_IDLE: begin
          // Entering a fault flushes the pipeline, so both fault bits go at once.
          if (req_stk) begin
            state_n = TS_EXC_S1;
            clr_exc = 1'b1;
          end else if (req_mem) begin
            state_n = TS_EXC_M1;
            clr_exc = 1'b1;
          end else if (req_int) begin
            state_n = TS_INT_1;
            clr_int = 1'b1;
          end
        end
        TS_EXC_S1: state_n = TS_EXC_S2;
        TS_EXC_M1: state_n = TS_EXC_M2;
        TS_INT_1:  state_n = TS_INT_2;
        TS_INT_2:  state_n = TS_INT_3;
        default:   state_n = TS_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= TS_IDLE;
      exceptions_o <= EXC_CODE_NONE;
      interrupts_o <= INT_CODE_NONE;
      busy_o       <= 1'b0;
    end else begin
      state_q      <= state_n;
      exceptions_o <= exc_code(state_n);
      interrupts_o <= int_code(state_n);
      busy_o       <= (state_n != TS_IDLE);
    end
  end

`ifdef TRAP_EPC_EN
  logic [PC_W-1:0] epc_q;

  always_ff @(posedge clk) begin
    if (reset)
      epc_q <= '0;
    else if ((exc_stack_i | exc_mem_i) && !fault_pending)
      epc_q <= pc_i;
  end

  assign epc_o = epc_q;
`else
  logic unused_epc;

  assign unused_epc = ^{pc_i, fault_pending};
  assign epc_o      = '0;
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - vector table, directed sequences and randomized reference-model bench
module tb_trap_sequencer;

  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall_i;
  logic            exc_stack_i;
  logic            exc_mem_i;
  logic            int_i;
  logic [PC_W-1:0] pc_i;
  logic [3:0]      exceptions_o;
  logic [2:0]      interrupts_o;
  logic            busy_o;
  logic [PC_W-1:0] epc_o;

  trap_sequencer #(.PC_W(PC_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall_i),
    .exc_stack_i  (exc_stack_i),
    .exc_mem_i    (exc_mem_i),
    .int_i        (int_i),
    .pc_i         (pc_i),
    .exceptions_o (exceptions_o),
    .interrupts_o (interrupts_o),
    .busy_o       (busy_o),
    .epc_o        (epc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              rst;
    bit              stall;
    bit              stk;
    bit              mem;
    bit              intr;
    logic [PC_W-1:0] pc;
    logic [3:0]      exc;
    logic [2:0]      irq;
    logic [PC_W-1:0] epc;
  } vec_t;

  typedef struct packed {
    logic [3:0] e;
    logic [2:0] i;
  } phase_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passes = 0;

  function automatic logic [PC_W-1:0] epc_want(logic [PC_W-1:0] p);
`ifdef TRAP_EPC_EN
    return p;
`else
    return (p & '0);
`endif
  endfunction

  function automatic void add(bit r, bit s, bit k, bit m, bit i, logic [PC_W-1:0] pc,
                              logic [3:0] e, logic [2:0] q, logic [PC_W-1:0] ep);
    vec_t v;
    v.rst = r; v.stall = s; v.stk = k; v.mem = m; v.intr = i; v.pc = pc;
    v.exc = e; v.irq = q; v.epc = ep;
    vecs.push_back(v);
  endfunction

  task automatic drive(bit r, bit s, bit k, bit m, bit i, logic [PC_W-1:0] pc);
    reset = r; stall_i = s; exc_stack_i = k; exc_mem_i = m; int_i = i; pc_i = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [3:0] e, logic [2:0] q, logic [PC_W-1:0] ep);
    logic            b;
    logic [PC_W-1:0] w;
    b = (e != 4'b0) || (q != 3'b0);
    w = epc_want(ep);
    checks++;
    if (exceptions_o !== e || interrupts_o !== q || busy_o !== b || epc_o !== w)
      $display("FAIL %s: got exc=%b int=%b busy=%b epc=%h, want exc=%b int=%b busy=%b epc=%h",
               name, exceptions_o, interrupts_o, busy_o, epc_o, e, q, b, w);
    else
      passes++;
  endtask

  // Reference model: pending flags plus a queue of the phase codes still to be shown.
  bit              m_stk, m_mem, m_int, m_prev;
  phase_t          m_q[$];
  phase_t          m_out;
  logic [PC_W-1:0] m_epc;

  function automatic void model_step(bit r, bit s, bit k, bit m, bit i, logic [PC_W-1:0] pc);
    bit edge_seen;
    if (r) begin
      m_stk = 0; m_mem = 0; m_int = 0; m_prev = 0;
      m_q.delete();
      m_out = '0;
      m_epc = '0;
      return;
    end
    edge_seen = i && !m_prev;
    m_prev = i;
    if ((k || m) && !m_stk && !m_mem) m_epc = pc;
    m_stk |= k;
    m_mem |= m;
    m_int |= edge_seen;
    if (s) return;
    if (m_q.size() > 0) begin
      m_out = m_q.pop_front();
    end else if (m_stk) begin
      m_out = '{4'b0001, 3'b000};
      m_q.push_back('{4'b0100, 3'b000});
      m_q.push_back('{4'b0000, 3'b000});
      m_stk = 0; m_mem = 0;
    end else if (m_mem) begin
      m_out = '{4'b0010, 3'b000};
      m_q.push_back('{4'b1000, 3'b000});
      m_q.push_back('{4'b0000, 3'b000});
      m_stk = 0; m_mem = 0;
    end else if (m_int) begin
      m_out = '{4'b0000, 3'b001};
      m_q.push_back('{4'b0000, 3'b010});
      m_q.push_back('{4'b0000, 3'b100});
      m_q.push_back('{4'b0000, 3'b000});
      m_int = 0;
    end else begin
      m_out = '0;
    end
  endfunction

  initial begin
    reset = 1'b1; stall_i = 1'b0; exc_stack_i = 1'b0; exc_mem_i = 1'b0; int_i = 1'b0; pc_i = '0;

    // reset, then stack fault in cycle 5
    add(1,0,0,0,0, 32'h0,   4'b0000, 3'b000, 32'h0);
    for (int n = 0; n < 4; n++) add(0,0,0,0,0, 32'h0, 4'b0000, 3'b000, 32'h0);
    add(0,0,1,0,0, 32'h100, 4'b0001, 3'b000, 32'h100);
    add(0,0,0,0,0, 32'h0,   4'b0100, 3'b000, 32'h100);
    add(0,0,0,0,0, 32'h0,   4'b0000, 3'b000, 32'h100);
    // stack + memory together: memory fault flushed
    add(0,0,1,1,0, 32'h200, 4'b0001, 3'b000, 32'h200);
    add(0,0,0,0,0, 32'h0,   4'b0100, 3'b000, 32'h200);
    for (int n = 0; n < 3; n++) add(0,0,0,0,0, 32'h0, 4'b0000, 3'b000, 32'h200);
    // interrupt rise, held high: single sequence
    add(0,0,0,0,1, 32'h0,   4'b0000, 3'b001, 32'h200);
    add(0,0,0,0,1, 32'h0,   4'b0000, 3'b010, 32'h200);
    add(0,0,0,0,1, 32'h0,   4'b0000, 3'b100, 32'h200);
    for (int n = 0; n < 3; n++) add(0,0,0,0,1, 32'h0, 4'b0000, 3'b000, 32'h200);
    add(0,0,0,0,0, 32'h0,   4'b0000, 3'b000, 32'h200);
    // stall three cycles in INT_2
    add(0,0,0,0,1, 32'h0,   4'b0000, 3'b001, 32'h200);
    add(0,0,0,0,1, 32'h0,   4'b0000, 3'b010, 32'h200);
    for (int n = 0; n < 3; n++) add(0,1,0,0,1, 32'h0, 4'b0000, 3'b010, 32'h200);
    add(0,0,0,0,1, 32'h0,   4'b0000, 3'b100, 32'h200);
    add(0,0,0,0,0, 32'h0,   4'b0000, 3'b000, 32'h200);
    // memory fault during INT_2 waits for the interrupt to finish
    add(0,0,0,0,1, 32'h0,   4'b0000, 3'b001, 32'h200);
    add(0,0,0,0,0, 32'h0,   4'b0000, 3'b010, 32'h200);
    add(0,0,0,1,0, 32'h1A4, 4'b0000, 3'b100, 32'h1A4);
    add(0,0,0,0,0, 32'h0,   4'b0000, 3'b000, 32'h1A4);
    add(0,0,0,0,0, 32'h0,   4'b0010, 3'b000, 32'h1A4);
    add(0,0,0,0,0, 32'h0,   4'b1000, 3'b000, 32'h1A4);
    add(0,0,0,0,0, 32'h0,   4'b0000, 3'b000, 32'h1A4);
    // reset in EXC_M1 aborts; fault during reset is ignored
    add(0,0,0,1,0, 32'h300, 4'b0010, 3'b000, 32'h300);
    add(1,0,1,0,0, 32'h600, 4'b0000, 3'b000, 32'h0);
    for (int n = 0; n < 3; n++) add(0,0,0,0,0, 32'h0, 4'b0000, 3'b000, 32'h0);

    foreach (vecs[n]) begin
      drive(vecs[n].rst, vecs[n].stall, vecs[n].stk, vecs[n].mem, vecs[n].intr, vecs[n].pc);
      check($sformatf("vec%0d", n), vecs[n].exc, vecs[n].irq, vecs[n].epc);
    end

    // faults latched while stalled in IDLE; EPC keeps the first one
    drive(0,1,0,1,0, 32'h400); check("stall_mem",  4'b0000, 3'b000, 32'h400);
    drive(0,1,1,0,0, 32'h500); check("stall_stk",  4'b0000, 3'b000, 32'h400);
    drive(0,0,0,0,0, 32'h0);   check("unstall_s1", 4'b0001, 3'b000, 32'h400);
    drive(0,0,0,0,0, 32'h0);   check("unstall_s2", 4'b0100, 3'b000, 32'h400);
    drive(0,0,0,0,0, 32'h0);   check("flushed_0",  4'b0000, 3'b000, 32'h400);
    drive(0,0,0,0,0, 32'h0);   check("flushed_1",  4'b0000, 3'b000, 32'h400);

    // interrupt edge with a stack fault: fault first, interrupt kept
    drive(0,0,1,0,1, 32'h700); check("both_s1",    4'b0001, 3'b000, 32'h700);
    drive(0,0,0,0,0, 32'h0);   check("both_s2",    4'b0100, 3'b000, 32'h700);
    drive(0,0,0,0,0, 32'h0);   check("both_idle",  4'b0000, 3'b000, 32'h700);
    drive(0,0,0,0,0, 32'h0);   check("both_i1",    4'b0000, 3'b001, 32'h700);
    drive(0,0,0,0,1, 32'h0);   check("both_i2",    4'b0000, 3'b010, 32'h700);
    drive(0,0,0,0,0, 32'h0);   check("both_i3",    4'b0000, 3'b100, 32'h700);
    drive(0,0,0,0,0, 32'h0);   check("reedge_idle",4'b0000, 3'b000, 32'h700);
    drive(0,0,0,0,0, 32'h0);   check("reedge_i1",  4'b0000, 3'b001, 32'h700);

    // randomized run against the reference model
    drive(1,0,0,0,0, 32'h0);
    model_step(1,0,0,0,0, 32'h0);
    check("rand_reset", m_out.e, m_out.i, m_epc);
    for (int n = 0; n < 3000; n++) begin
      bit              r, s, k, m, i;
      logic [PC_W-1:0] pc;
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 3) == 0);
      k  = ($urandom_range(0, 15) == 0);
      m  = ($urandom_range(0, 15) == 0);
      i  = ($urandom_range(0, 4) == 0) ? !int_i : int_i;
      pc = $urandom;
      model_step(r, s, k, m, i, pc);
      drive(r, s, k, m, i, pc);
      check($sformatf("rand%0d", n), m_out.e, m_out.i, m_epc);
      checks++;
      if (($countones(exceptions_o) <= 1) && ($countones(interrupts_o) <= 1) &&
          !((exceptions_o != 4'b0) && (interrupts_o != 3'b0)))
        passes++;
      else
        $display("FAIL onehot%0d: got exc=%b int=%b, want at most one one-hot code",
                 n, exceptions_o, interrupts_o);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
